// File: rtl/spi_pkg.sv
// Shared types for the SPI target byte engine: mode encoding, FSM states and named mode constants.
package spi_pkg;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_e;

    localparam spi_mode_t MODE0 = '{cpol: 1'b0, cpha: 1'b0};
    localparam spi_mode_t MODE1 = '{cpol: 1'b0, cpha: 1'b1};
    localparam spi_mode_t MODE2 = '{cpol: 1'b1, cpha: 1'b0};
    localparam spi_mode_t MODE3 = '{cpol: 1'b1, cpha: 1'b1};

endpackage

// File: rtl/spi_byte_engine_edge_detect.sv
// Single-bit edge detector on an already-synchronized input; the previous value resets low.
module edge_detect (
    input  logic rst,
    input  logic clk,
    input  logic ena,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic d_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_prev <= 1'b0;
        end else if (ena) begin
            d_prev <= d;
        end
    end

    assign rise = ~d_prev & d;
    assign fall = d_prev & ~d;

endmodule

// File: rtl/spi_byte_engine.sv
// SPI target serial engine: deserializes MOSI into words, serializes tx words onto MISO, modes 0-3, MSB first.
module spi_byte_engine
    import spi_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic [1:0]        mode,
    input  logic              spi_cs_n,
    input  logic              spi_clk,
    input  logic              spi_mosi,
    output logic              spi_miso,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_load,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic [CNT_W-1:0]  word_cnt,
    output logic              frame_start,
    output logic              frame_end,
    output logic              frame_abort
);

    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    spi_state_e        state_q, state_d;
    spi_mode_t         mode_q;
    logic [BIT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] rx_sr;
    logic [DATA_W-1:0] tx_sr;

    logic cs_rise, cs_fall;
    logic sclk_rise, sclk_fall;
    logic sclk_edge, leading, sample_edge, shift_edge;

    edge_detect u_cs_edge (
        .rst  (rst),
        .clk  (clk),
        .ena  (ena),
        .d    (spi_cs_n),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    edge_detect u_sclk_edge (
        .rst  (rst),
        .clk  (clk),
        .ena  (ena),
        .d    (spi_clk),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    // Leading edge moves SCLK away from its idle level; cpha selects which edge samples.
    assign sclk_edge   = sclk_rise | sclk_fall;
    assign leading     = spi_clk ^ mode_q.cpol;
    assign sample_edge = sclk_edge & (leading ^ mode_q.cpha);
    assign shift_edge  = sclk_edge & ~(leading ^ mode_q.cpha);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else if (ena) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cs_fall) state_d = ACTIVE;
            ACTIVE:  if (cs_rise) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // CS events take priority over any SCLK edge seen in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q      <= MODE0;
            bit_cnt     <= '0;
            rx_sr       <= '0;
            tx_sr       <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            word_cnt    <= '0;
            tx_load     <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            tx_load     <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            frame_abort <= 1'b0;
            if (ena) begin
                if (state_q == IDLE && cs_fall) begin
                    mode_q      <= spi_mode_t'(mode);
                    bit_cnt     <= '0;
                    rx_sr       <= '0;
                    word_cnt    <= '0;
                    frame_start <= 1'b1;
                    if (!mode[0]) begin
                        tx_sr   <= tx_data;
                        tx_load <= 1'b1;
                    end
                end else if (state_q == ACTIVE && cs_rise) begin
                    frame_end   <= 1'b1;
                    frame_abort <= (bit_cnt != '0);
                    bit_cnt     <= '0;
                    rx_sr       <= '0;
                end else if (state_q == ACTIVE) begin
                    if (sample_edge) begin
                        rx_sr <= {rx_sr[DATA_W-2:0], spi_mosi};
                        if (bit_cnt == BIT_W'(DATA_W - 1)) begin
                            rx_data  <= {rx_sr[DATA_W-2:0], spi_mosi};
                            rx_valid <= 1'b1;
                            word_cnt <= word_cnt + CNT_W'(1);
                            bit_cnt  <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end
                    if (shift_edge) begin
                        if (bit_cnt == '0) begin
                            tx_sr   <= tx_data;
                            tx_load <= 1'b1;
                        end else begin
                            tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
                        end
                    end
                end
            end
        end
    end

    assign spi_miso = (state_q == ACTIVE) & tx_sr[DATA_W-1];

endmodule

// File: tb/tb_spi_byte_engine.sv
// Directed bench for spi_byte_engine: acts as SPI controller with synchronized-level stimulus.
module tb_spi_byte_engine;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              ena;
    logic [1:0]        mode;
    logic              spi_cs_n;
    logic              spi_clk;
    logic              spi_mosi;
    logic              spi_miso;
    logic [DATA_W-1:0] tx_data;
    logic              tx_load;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic [CNT_W-1:0]  word_cnt;
    logic              frame_start;
    logic              frame_end;
    logic              frame_abort;

    spi_byte_engine #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .mode        (mode),
        .spi_cs_n    (spi_cs_n),
        .spi_clk     (spi_clk),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .tx_data     (tx_data),
        .tx_load     (tx_load),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .word_cnt    (word_cnt),
        .frame_start (frame_start),
        .frame_end   (frame_end),
        .frame_abort (frame_abort)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Pulse counters and received-word log, sampled away from the active edge.
    int         n_rxv = 0, n_txl = 0, n_fs = 0, n_fe = 0, n_fa = 0;
    logic [7:0] rx_log[$];

    always @(negedge clk) begin
        if (rx_valid) begin
            n_rxv++;
            rx_log.push_back(rx_data);
        end
        if (tx_load)     n_txl++;
        if (frame_start) n_fs++;
        if (frame_end)   n_fe++;
        if (frame_abort) n_fa++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic spi_bit(input logic [1:0] m, input logic mo, output logic mi);
        if (!m[0]) begin
            spi_mosi = mo;
            wait_clk(4);
            mi = spi_miso;
            spi_clk = ~m[1];
            wait_clk(4);
            spi_clk = m[1];
        end else begin
            spi_clk  = ~m[1];
            spi_mosi = mo;
            wait_clk(4);
            mi = spi_miso;
            spi_clk = m[1];
            wait_clk(4);
        end
    endtask

    task automatic spi_byte(input logic [1:0] m, input logic [7:0] mo,
                            input logic [7:0] next_tx, output logic [7:0] mi);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(m, mo[i], b);
            mi[i] = b;
            if (i == 7) tx_data = next_tx;
        end
    endtask

    task automatic frame_begin(input logic [1:0] m, input logic [7:0] first_tx);
        tx_data  = first_tx;
        mode     = m;
        spi_clk  = m[1];
        spi_cs_n = 1'b1;
        wait_clk(4);
        spi_cs_n = 1'b0;
        wait_clk(4);
    endtask

    task automatic frame_close();
        wait_clk(4);
        spi_cs_n = 1'b1;
        wait_clk(4);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_miso"},   {31'd0, spi_miso},    32'd0);
        chk({tag, "_rxdata"}, {24'd0, rx_data},     32'd0);
        chk({tag, "_rxv"},    {31'd0, rx_valid},    32'd0);
        chk({tag, "_wcnt"},   {24'd0, word_cnt},    32'd0);
        chk({tag, "_txl"},    {31'd0, tx_load},     32'd0);
        chk({tag, "_fs"},     {31'd0, frame_start}, 32'd0);
        chk({tag, "_fe"},     {31'd0, frame_end},   32'd0);
        chk({tag, "_fa"},     {31'd0, frame_abort}, 32'd0);
    endtask

    initial begin
        logic [7:0] mi, mi0, mi1, mi2;
        logic       b;
        int         rxv0, txl0, fs0, fe0, fa0;
        logic [1:0] m;

        rst = 1'b1; ena = 1'b1; mode = 2'b00; spi_cs_n = 1'b1;
        spi_clk = 1'b0; spi_mosi = 1'b0; tx_data = 8'h00;
        wait_clk(3);
        chk_idle_outputs("rst_held");
        rst = 1'b0;
        wait_clk(3);
        chk_idle_outputs("rst_released");

        // Single-byte transfer in every mode: tx A5, MOSI 3C
        for (int k = 0; k < 4; k++) begin
            m = 2'(k);
            rxv0 = n_rxv; txl0 = n_txl; fs0 = n_fs; fe0 = n_fe; fa0 = n_fa;
            frame_begin(m, 8'hA5);
            spi_byte(m, 8'h3C, 8'h00, mi);
            frame_close();
            chk($sformatf("m%0d_rxdata", k), {24'd0, rx_data}, 32'h3C);
            chk($sformatf("m%0d_rxv", k),    n_rxv - rxv0, 32'd1);
            chk($sformatf("m%0d_miso", k),   {24'd0, mi}, 32'hA5);
            chk($sformatf("m%0d_wcnt", k),   {24'd0, word_cnt}, 32'd1);
            chk($sformatf("m%0d_txl", k),    n_txl - txl0, m[0] ? 32'd1 : 32'd2);
            chk($sformatf("m%0d_fs", k),     n_fs - fs0, 32'd1);
            chk($sformatf("m%0d_fe", k),     n_fe - fe0, 32'd1);
            chk($sformatf("m%0d_fa", k),     n_fa - fa0, 32'd0);
            chk($sformatf("m%0d_miso_idle", k), {31'd0, spi_miso}, 32'd0);
        end

        // Three-word frames, cpha=0 (mode 0) and cpha=1 (mode 3)
        for (int k = 0; k < 2; k++) begin
            m = (k == 0) ? 2'b00 : 2'b11;
            rxv0 = n_rxv; txl0 = n_txl;
            frame_begin(m, 8'h11);
            spi_byte(m, 8'h5A, 8'h22, mi0);
            spi_byte(m, 8'hC3, 8'h33, mi1);
            spi_byte(m, 8'h0F, 8'h44, mi2);
            wait_clk(2);
            chk($sformatf("w3_m%0d_wcnt", m), {24'd0, word_cnt}, 32'd3);
            frame_close();
            chk($sformatf("w3_m%0d_rxv", m), n_rxv - rxv0, 32'd3);
            chk($sformatf("w3_m%0d_rx0", m), {24'd0, rx_log[rx_log.size()-3]}, 32'h5A);
            chk($sformatf("w3_m%0d_rx1", m), {24'd0, rx_log[rx_log.size()-2]}, 32'hC3);
            chk($sformatf("w3_m%0d_rx2", m), {24'd0, rx_log[rx_log.size()-1]}, 32'h0F);
            chk($sformatf("w3_m%0d_tx", m),  {8'd0, mi0, mi1, mi2}, 32'h112233);
            chk($sformatf("w3_m%0d_txl", m), n_txl - txl0, m[0] ? 32'd3 : 32'd4);
        end

        // Partial word aborted after 5 bits, then a clean frame
        rxv0 = n_rxv; fe0 = n_fe; fa0 = n_fa;
        frame_begin(2'b00, 8'hF0);
        for (int i = 0; i < 5; i++) spi_bit(2'b00, 1'b1, b);
        frame_close();
        chk("abort_fe",   n_fe - fe0, 32'd1);
        chk("abort_fa",   n_fa - fa0, 32'd1);
        chk("abort_rxv",  n_rxv - rxv0, 32'd0);
        chk("abort_wcnt", {24'd0, word_cnt}, 32'd0);
        frame_begin(2'b00, 8'h5A);
        spi_byte(2'b00, 8'h96, 8'h00, mi);
        frame_close();
        chk("after_abort_rx",   {24'd0, rx_data}, 32'h96);
        chk("after_abort_miso", {24'd0, mi}, 32'h5A);

        // Reset mid-byte with CS held low: no activity until CS high then low
        frame_begin(2'b00, 8'hFF);
        for (int i = 0; i < 3; i++) spi_bit(2'b00, 1'b1, b);
        rst = 1'b1;
        wait_clk(2);
        rst = 1'b0;
        wait_clk(1);
        chk_idle_outputs("midrst");
        rxv0 = n_rxv; fs0 = n_fs;
        for (int i = 0; i < 8; i++) begin
            spi_bit(2'b00, 1'b1, b);
            chk($sformatf("midrst_miso%0d", i), {31'd0, b}, 32'd0);
        end
        chk("midrst_rxv", n_rxv - rxv0, 32'd0);
        chk("midrst_fs",  n_fs - fs0, 32'd0);
        frame_begin(2'b00, 8'hC6);
        spi_byte(2'b00, 8'h81, 8'h00, mi);
        frame_close();
        chk("postrst_rx",   {24'd0, rx_data}, 32'h81);
        chk("postrst_miso", {24'd0, mi}, 32'hC6);

        // SCLK activity with CS high is ignored
        rxv0 = n_rxv; txl0 = n_txl;
        for (int i = 0; i < 16; i++) begin
            spi_clk  = ~spi_clk;
            spi_mosi = 1'(i);
            wait_clk(3);
        end
        chk("cshigh_rxv",  n_rxv - rxv0, 32'd0);
        chk("cshigh_txl",  n_txl - txl0, 32'd0);
        chk("cshigh_wcnt", {24'd0, word_cnt}, 32'd1);
        chk("cshigh_miso", {31'd0, spi_miso}, 32'd0);

        // Mode input changes mid-frame; latched mode 0 must stay in force
        frame_begin(2'b00, 8'hC3);
        for (int i = 7; i >= 4; i--) begin spi_bit(2'b00, 8'h69 >> i, b); mi[i] = b; end
        mode = 2'b11;
        for (int i = 3; i >= 0; i--) begin spi_bit(2'b00, 8'h69 >> i, b); mi[i] = b; end
        frame_close();
        chk("modechg_rx",   {24'd0, rx_data}, 32'h69);
        chk("modechg_miso", {24'd0, mi}, 32'hC3);

        // ena low for 10 clk with an SCLK pulse inside: state frozen, edge invisible
        rxv0 = n_rxv;
        frame_begin(2'b01, 8'h99);
        for (int i = 7; i >= 4; i--) begin spi_bit(2'b01, 8'hE7 >> i, b); mi[i] = b; end
        ena = 1'b0;
        spi_clk = 1'b1;
        wait_clk(5);
        spi_clk = 1'b0;
        wait_clk(5);
        chk("ena_miso_held", {31'd0, spi_miso}, 32'd1);
        chk("ena_wcnt_held", {24'd0, word_cnt}, 32'd0);
        ena = 1'b1;
        for (int i = 3; i >= 0; i--) begin spi_bit(2'b01, 8'hE7 >> i, b); mi[i] = b; end
        frame_close();
        chk("ena_rx",   {24'd0, rx_data}, 32'hE7);
        chk("ena_miso", {24'd0, mi}, 32'h99);
        chk("ena_rxv",  n_rxv - rxv0, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
